// File: rtl/demux_pkg.sv
// Shared constants for the eight-bit stream demultiplexer: default geometry
// and the ceiling of the dropped-word counter.
package demux_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_NCH   = 3;
    localparam int DEF_SELW  = 2;

    // err_cnt sticks here instead of wrapping, so a long burst of bad
    // selects never reads back as a small number.
    localparam logic [7:0] ERR_CNT_MAX = 8'd255;

endpackage

// File: rtl/demux_channel_slot.sv
// One-entry output register for a single demux channel.
// A load always wins over a drain, so a simultaneous drain and load replaces
// the word and keeps the slot full for one-word-per-cycle throughput.
module demux_channel_slot #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] data_in,
    input  logic             ready,
    output logic             valid,
    output logic [WIDTH-1:0] data_out
);

    // Slot occupancy: set on load, cleared on a downstream accept without reload.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

    // Held word: only a load changes it, so it is stable under backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out <= '0;
        end else if (load) begin
            data_out <= data_in;
        end
    end

endmodule

// File: rtl/eight_bit_stream_demux.sv
// Stream demultiplexer: routes each accepted upstream word to one channel
// slot chosen by in_sel, or to every slot when in_bcast is set. Words with an
// out-of-range select are accepted and dropped, and counted in err_cnt.
module eight_bit_stream_demux
    import demux_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int NCH   = DEF_NCH,
    parameter int SELW  = DEF_SELW
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_data,
    input  logic [SELW-1:0]      in_sel,
    input  logic                 in_bcast,
    output logic [NCH-1:0]       out_valid,
    input  logic [NCH-1:0]       out_ready,
    output logic [NCH*WIDTH-1:0] out_data,
    output logic [7:0]           err_cnt
);

    // Select space may be larger than the channel count; the unused codes are
    // the "drop" selects.
    localparam int NSEL = 2 ** SELW;

    logic [NCH-1:0]  can_load;
    logic [NSEL-1:0] can_load_pad;
    logic [NCH-1:0]  load;
    logic            sel_ok;
    logic            xfer;
    logic            drop;

    // Per-slot can-load: empty now, or being drained this cycle.
    always_comb begin
        can_load = ~out_valid | out_ready;
    end

    // Widen can-load to the full select space; out-of-range selects always
    // accept because the word is simply discarded.
    always_comb begin
        can_load_pad = '1;
        for (int k = 0; k < NCH; k++) begin
            can_load_pad[k] = can_load[k];
        end
    end

    // Upstream ready: all slots for broadcast, the selected slot otherwise.
    // Deliberately independent of in_valid.
    always_comb begin
        sel_ok   = (int'(in_sel) < NCH);
        in_ready = in_bcast ? (&can_load) : can_load_pad[in_sel];
        xfer     = in_valid && in_ready;
        drop     = xfer && !in_bcast && !sel_ok;
    end

    // Select decode: one-hot load for unicast, all slots for broadcast.
    always_comb begin
        load = '0;
        for (int k = 0; k < NCH; k++) begin
            load[k] = xfer && (in_bcast || (int'(in_sel) == k));
        end
    end

    // Saturating count of words dropped for an out-of-range select.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= 8'd0;
        end else if (drop && (err_cnt != ERR_CNT_MAX)) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end

    for (genvar k = 0; k < NCH; k++) begin : g_slot
        demux_channel_slot #(
            .WIDTH (WIDTH)
        ) u_slot (
            .clk      (clk),
            .rst_n    (rst_n),
            .load     (load[k]),
            .data_in  (in_data),
            .ready    (out_ready[k]),
            .valid    (out_valid[k]),
            .data_out (out_data[k*WIDTH +: WIDTH])
        );
    end

endmodule

// File: tb/tb_eight_bit_stream_demux.sv
// Directed bench for eight_bit_stream_demux (WIDTH=8, NCH=3, SELW=2).
// Inputs change 1 ns after a rising edge; outputs are sampled 1-2 ns later.
module tb_eight_bit_stream_demux;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic [1:0]  in_sel;
    logic        in_bcast;
    logic [2:0]  out_valid;
    logic [2:0]  out_ready;
    logic [23:0] out_data;
    logic [7:0]  err_cnt;

    int checks   = 0;
    int failures = 0;

    eight_bit_stream_demux #(.WIDTH(8), .NCH(3), .SELW(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_bcast  (in_bcast),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .err_cnt   (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; in_sel = 2'd0;
        in_bcast = 1'b0; out_ready = 3'b111;
        #12;
        checks++;
        if (out_valid !== 3'b000) begin
            failures++; $display("FAIL reset_valid got=%b exp=000", out_valid);
        end
        checks++;
        if (out_data !== 24'h0) begin
            failures++; $display("FAIL reset_data got=%h exp=000000", out_data);
        end
        checks++;
        if (err_cnt !== 8'd0) begin
            failures++; $display("FAIL reset_err got=%0d exp=0", err_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_unicast();
        out_ready = 3'b111; in_bcast = 1'b0;
        in_sel = 2'd1; in_data = 8'hA5; in_valid = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++; $display("FAIL uni_ready got=%b exp=1", in_ready);
        end
        step();
        in_valid = 1'b0;
        #1;
        checks++;
        if (out_valid !== 3'b010) begin
            failures++; $display("FAIL uni_valid got=%b exp=010", out_valid);
        end
        checks++;
        if (out_data[15:8] !== 8'hA5) begin
            failures++; $display("FAIL uni_data got=%h exp=a5", out_data[15:8]);
        end
        step();
        checks++;
        if (out_valid !== 3'b000) begin
            failures++; $display("FAIL uni_empty got=%b exp=000", out_valid);
        end
    endtask

    task automatic test_backpressure();
        out_ready = 3'b110; in_bcast = 1'b0;
        in_sel = 2'd0; in_data = 8'h11; in_valid = 1'b1;
        step();
        in_data = 8'h22;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            failures++; $display("FAIL bp_ready_sel0 got=%b exp=0", in_ready);
        end
        in_valid = 1'b0; in_sel = 2'd2;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++; $display("FAIL bp_ready_sel2 got=%b exp=1", in_ready);
        end
        in_sel = 2'd0; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (out_valid[0] !== 1'b1 || out_data[7:0] !== 8'h11) begin
                failures++;
                $display("FAIL bp_hold cyc=%0d valid=%b data=%h exp=1/11", i, out_valid[0], out_data[7:0]);
            end
        end
        out_ready = 3'b111;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++; $display("FAIL bp_ready_release got=%b exp=1", in_ready);
        end
        step();
        in_valid = 1'b0;
        checks++;
        if (out_valid[0] !== 1'b1 || out_data[7:0] !== 8'h22) begin
            failures++;
            $display("FAIL bp_follow valid=%b data=%h exp=1/22", out_valid[0], out_data[7:0]);
        end
        step();
        checks++;
        if (out_valid !== 3'b000) begin
            failures++; $display("FAIL bp_empty got=%b exp=000", out_valid);
        end
    endtask

    task automatic test_broadcast();
        out_ready = 3'b000; in_bcast = 1'b1; in_sel = 2'd3;
        in_data = 8'h77; in_valid = 1'b1;
        step();
        in_data = 8'h3C; out_ready = 3'b101;
        #1;
        checks++;
        if (out_valid !== 3'b111) begin
            failures++; $display("FAIL bc_fill got=%b exp=111", out_valid);
        end
        checks++;
        if (in_ready !== 1'b0) begin
            failures++; $display("FAIL bc_ready_full got=%b exp=0", in_ready);
        end
        in_valid = 1'b0; out_ready = 3'b111;
        step();
        checks++;
        if (out_valid !== 3'b000) begin
            failures++; $display("FAIL bc_drain got=%b exp=000", out_valid);
        end
        out_ready = 3'b101; in_valid = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++; $display("FAIL bc_ready_empty got=%b exp=1", in_ready);
        end
        step();
        in_valid = 1'b0; in_bcast = 1'b0;
        checks++;
        if (out_valid !== 3'b111 || out_data !== 24'h3C3C3C) begin
            failures++;
            $display("FAIL bc_data valid=%b data=%h exp=111/3c3c3c", out_valid, out_data);
        end
        out_ready = 3'b111;
        step();
    endtask

    task automatic test_invalid_sel();
        int seen;
        seen = 0;
        out_ready = 3'b111; in_bcast = 1'b0; in_sel = 2'd3;
        in_data = 8'hEE; in_valid = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++; $display("FAIL inv_ready got=%b exp=1", in_ready);
        end
        for (int i = 1; i <= 300; i++) begin
            step();
            if (out_valid !== 3'b000) seen++;
            if (i == 5) begin
                checks++;
                if (err_cnt !== 8'd5) begin
                    failures++; $display("FAIL inv_err5 got=%0d exp=5", err_cnt);
                end
            end
        end
        in_valid = 1'b0;
        checks++;
        if (seen != 0) begin
            failures++; $display("FAIL inv_leak cycles_with_valid=%0d exp=0", seen);
        end
        checks++;
        if (err_cnt !== 8'd255) begin
            failures++; $display("FAIL inv_sat got=%0d exp=255", err_cnt);
        end
        step();
    endtask

    task automatic test_back_to_back();
        logic [2:0] exp_v;
        logic [7:0] exp_d;
        int stalls;
        stalls = 0;
        out_ready = 3'b111; in_bcast = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            in_sel  = 2'(i % 3);
            in_data = 8'h40 + 8'(i);
            exp_v   = 3'b001 << (i % 3);
            exp_d   = 8'h40 + 8'(i);
            #1;
            if (in_ready !== 1'b1) stalls++;
            step();
            checks++;
            if (out_valid !== exp_v || out_data[(i % 3)*8 +: 8] !== exp_d) begin
                failures++;
                $display("FAIL tput_word%0d valid=%b data=%h exp=%b/%h", i, out_valid,
                         out_data[(i % 3)*8 +: 8], exp_v, exp_d);
            end
        end
        in_valid = 1'b0;
        checks++;
        if (stalls != 0) begin
            failures++; $display("FAIL tput_stalls got=%0d exp=0", stalls);
        end
        step();
    endtask

    task automatic test_reset_midstream();
        out_ready = 3'b000; in_bcast = 1'b1; in_data = 8'h5A; in_valid = 1'b1;
        step();
        in_valid = 1'b0; in_bcast = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 3'b000 || out_data !== 24'h0 || err_cnt !== 8'd0) begin
            failures++;
            $display("FAIL mid_reset valid=%b data=%h err=%0d exp=000/000000/0", out_valid, out_data, err_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 3'b111; in_sel = 2'd0; in_data = 8'h99; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 3'b001 || out_data[7:0] !== 8'h99) begin
            failures++;
            $display("FAIL mid_first_load valid=%b data=%h exp=001/99", out_valid, out_data[7:0]);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_unicast();
        test_backpressure();
        test_broadcast();
        test_invalid_sel();
        test_back_to_back();
        test_reset_midstream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/eight_bit_stream_demux.md
EIGHT_BIT_STREAM_DEMUX -- requirements
Module: eight_bit_stream_demux

Interface
REQ-001 Parameter WIDTH, default 8, bits per data word.
REQ-002 Parameter NCH, default 3, number of output channels (2..8).
REQ-003 Parameter SELW, default 2, select width; SHALL satisfy 2**SELW >= NCH.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 in_valid  input  1  upstream word present.
REQ-007 in_ready  output  1  block accepts word this cycle.
REQ-008 in_data  input  WIDTH  upstream word.
REQ-009 in_sel  input  SELW  destination channel index.
REQ-010 in_bcast  input  1  when 1, word goes to all channels and in_sel is ignored.
REQ-011 out_valid  output  NCH  per-channel word present.
REQ-012 out_ready  input  NCH  per-channel downstream accept.
REQ-013 out_data  output  NCH*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
REQ-014 err_cnt  output  8  saturating count of dropped words (in_sel >= NCH, in_bcast=0).

Function
REQ-015 Each channel SHALL hold a one-entry output register (slot); out_valid[k] means slot k is full.
REQ-016 Slot k can load in a cycle when out_valid[k]=0 or out_ready[k]=1.
REQ-017 Unicast (in_bcast=0, in_sel<NCH): in_ready SHALL equal the can-load condition of slot in_sel.
REQ-018 Broadcast (in_bcast=1): in_ready SHALL be 1 only when all NCH slots can load; on transfer, every slot loads in_data.
REQ-019 Invalid select (in_bcast=0, in_sel>=NCH): in_ready SHALL be 1; on in_valid the word is discarded, err_cnt increments by 1 and saturates at 255.
REQ-020 Transfer occurs when in_valid and in_ready are both 1; the loaded slot asserts out_valid on the next cycle (latency 1).
REQ-021 Downstream handshake: slot k empties when out_valid[k] and out_ready[k] are both 1 and no new load targets k.
REQ-022 Simultaneous drain and load on slot k SHALL replace the data and keep out_valid[k]=1 (full throughput, one word per cycle per channel).
REQ-023 While out_valid[k]=1 and out_ready[k]=0, out_data slice k SHALL stay stable.
REQ-024 in_ready SHALL be combinational from in_sel, in_bcast, out_valid and out_ready only; it SHALL NOT depend on in_valid.
REQ-025 Non-targeted slots SHALL be unaffected by a transfer.
REQ-026 Words on one channel SHALL be delivered in acceptance order; no word is duplicated except by broadcast.

Reset
REQ-027 While rst_n=0: out_valid all 0, out_data all 0, err_cnt 0, independent of clk.
REQ-028 Reset asserted mid-operation SHALL discard all held words; first load is possible on the first rising edge after rst_n deasserts.

Structure
REQ-029 Shared package demux_pkg SHALL hold default WIDTH/NCH/SELW constants and the err_cnt saturation limit (255).
REQ-030 One sub-module, demux_channel_slot (WIDTH parameter; load, data, ready in; valid, data out), SHALL be instantiated NCH times via a generate loop.
REQ-031 Select decode and broadcast ready-AND logic SHALL live in the top module.

Verification
REQ-032 Unicast: reset, in_sel=1, in_data=8'hA5, in_valid=1 for one cycle, out_ready=3'b111 -> next cycle out_valid=3'b010, slice 1 = 8'hA5, then empties.
REQ-033 Backpressure: out_ready[0]=0, send 8'h11 then 8'h22 to channel 0 -> 8'h11 held stable, in_ready=0 for sel=0 while in_ready=1 for sel=2; after out_ready[0]=1, 8'h22 follows on the next cycle.
REQ-034 Broadcast: in_bcast=1, in_data=8'h3C, out_ready=3'b101 with all slots full -> in_ready=0; with all slots empty -> all three slices = 8'h3C next cycle.
REQ-035 Invalid select: in_sel=3, 300 valid words -> nothing appears on any channel, err_cnt=255.
REQ-036 Throughput: out_ready=3'b111, stream 16 words round-robin sel 0,1,2 -> in_ready constantly 1, each word on its channel exactly one cycle after acceptance, order preserved.
REQ-037 Reset mid-stream: rst_n low with slots full -> out_valid=0, out_data=0 and err_cnt=0 immediately, without a clock edge.
